// File: rtl/dsa_pkg.sv
// Shared types and default sizing for the modular-exponentiation datapath.
package dsa_pkg;

  localparam int unsigned DefaultLen    = 2048;
  localparam int unsigned DefaultExpLen = 256;

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StSqr,
    StMul,
    StFinal,
    StDone
  } mont_state_e;

endpackage

// File: rtl/big_mul.sv
// Combinational LEN x LEN -> 2*LEN unsigned multiplier.
module big_mul #(
  parameter int unsigned LEN = 8
) (
  input  logic [LEN-1:0]   a,
  input  logic [LEN-1:0]   b,
  output logic [2*LEN-1:0] p
);

  logic [2*LEN-1:0] a_ext;
  logic [2*LEN-1:0] b_ext;

  assign a_ext = {{LEN{1'b0}}, a};
  assign b_ext = {{LEN{1'b0}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/mont_redc.sv
// Combinational Montgomery reduction: res = t * 2^-LEN mod n, for t < n * 2^LEN.
module mont_redc #(
  parameter int unsigned LEN = 8
) (
  input  logic [2*LEN-1:0] t,
  input  logic [LEN-1:0]   n,
  input  logic [LEN-1:0]   n_prime,
  output logic [LEN-1:0]   res
);

  logic [LEN-1:0]   m;
  logic [2*LEN-1:0] mn;
  logic             carry;
  logic [LEN:0]     u;
  logic [LEN:0]     u_sub;

  assign m  = t[LEN-1:0] * n_prime;
  assign mn = {{LEN{1'b0}}, m} * {{LEN{1'b0}}, n};

  // Low halves sum to 0 or exactly 2^LEN, and both are non-zero together.
  assign carry = (|t[LEN-1:0]) | (|mn[LEN-1:0]);

  assign u     = {1'b0, t[2*LEN-1:LEN]} + {1'b0, mn[2*LEN-1:LEN]} + {{LEN{1'b0}}, carry};
  assign u_sub = u - {1'b0, n};
  assign res   = (u >= {1'b0, n}) ? u_sub[LEN-1:0] : u[LEN-1:0];

endmodule

// File: rtl/mont_exp.sv
// Constant-time left-to-right Montgomery exponentiation, one redc per cycle.
module mont_exp
  import dsa_pkg::*;
#(
  parameter int unsigned LEN     = DefaultLen,
  parameter int unsigned EXP_LEN = DefaultExpLen
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LEN-1:0]     base,
  input  logic [EXP_LEN-1:0] exp,
  input  logic [LEN-1:0]     n,
  input  logic [LEN-1:0]     n_prime,
  input  logic [LEN-1:0]     r_mod_n,
  input  logic [LEN-1:0]     r2_mod_n,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEN-1:0]     result
);

  localparam int unsigned IdxW = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;

  mont_state_e        state_q;
  logic [LEN-1:0]     acc_q, base_m_q, result_q;
  logic [IdxW-1:0]    idx_q;
  logic [LEN-1:0]     base_q, n_q, n_prime_q, r_mod_q, r2_mod_q;
  logic [EXP_LEN-1:0] exp_q;
  logic               out_valid_q;

  logic [LEN-1:0]     op_a, op_b, redc_out;
  logic [2*LEN-1:0]   prod;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Single multiplier/reducer pair shared across states.
  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state_q)
      StConv:  begin op_a = base_q; op_b = r2_mod_q; end
      StSqr:   begin op_a = acc_q;  op_b = acc_q;    end
      StMul:   begin op_a = acc_q;  op_b = base_m_q; end
      StFinal: begin op_a = acc_q;  op_b = {{(LEN-1){1'b0}}, 1'b1}; end
      default: ;
    endcase
  end

  big_mul #(.LEN(LEN)) u_big_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  mont_redc #(.LEN(LEN)) u_mont_redc (
    .t       (prod),
    .n       (n_q),
    .n_prime (n_prime_q),
    .res     (redc_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      base_m_q    <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      base_q      <= '0;
      exp_q       <= '0;
      n_q         <= '0;
      n_prime_q   <= '0;
      r_mod_q     <= '0;
      r2_mod_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            base_q    <= base;
            exp_q     <= exp;
            n_q       <= n;
            n_prime_q <= n_prime;
            r_mod_q   <= r_mod_n;
            r2_mod_q  <= r2_mod_n;
            acc_q     <= r_mod_n;
            idx_q     <= IdxW'(EXP_LEN - 1);
            state_q   <= StConv;
          end
        end
        StConv: begin
          base_m_q <= redc_out;
          acc_q    <= r_mod_q;
          state_q  <= StSqr;
        end
        StSqr: begin
          acc_q   <= redc_out;
          state_q <= StMul;
        end
        StMul: begin
          // Product is always formed; only the write-back depends on the bit.
          if (exp_q[idx_q]) acc_q <= redc_out;
          if (idx_q == '0) begin
            state_q <= StFinal;
          end else begin
            idx_q   <= idx_q - IdxW'(1);
            state_q <= StSqr;
          end
        end
        StFinal: begin
          result_q    <= redc_out;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
